// File: rtl/definitions.sv
// Project-wide types and helpers shared by the launcher blocks.
package definitions;

    localparam int RUNS_BITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_NEXT     = 3'd3,
        ST_FINISH   = 3'd4
    } launch_state_e;

    // A requested batch of zero launches still launches the core once.
    function automatic logic [RUNS_BITS-1:0] norm_runs(input logic [RUNS_BITS-1:0] r);
        if (r == {RUNS_BITS{1'b0}}) begin
            return {{(RUNS_BITS-1){1'b0}}, 1'b1};
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that pins at all-ones instead of wrapping; clear wins over enable.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Count register with synchronous clear and saturation at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= {WIDTH{1'b0}};
        end else if (clear) begin
            count <= {WIDTH{1'b0}};
        end else if (enable && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/req_launcher.sv
// Launches a core with a registered req strobe, waits for its done level to rise,
// and reports per-run latency, batch progress and a sticky timeout flag.
module req_launcher
    import definitions::*;
#(
    parameter int REQ_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int CNT_BITS       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    input  logic [3:0]          runs,
    input  logic                ack,
    output logic                req,
    output logic                busy,
    output logic                finish,
    output logic                timeout,
    output logic [CNT_BITS-1:0] cycles,
    output logic [3:0]          runs_done
);

    localparam logic [3:0]  LAUNCH_LAST = 4'(REQ_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    launch_state_e       state_r;
    launch_state_e       state_n_s;
    logic [3:0]          launch_cnt_r;
    logic [3:0]          runs_cap_r;
    logic                ack_prev_r;
    logic                ack_rise_s;
    logic                launch_last_s;
    logic                timeout_hit_s;
    logic                wait_clr_s;
    logic [CNT_BITS-1:0] wait_cnt_s;

    // A done level left high from an earlier run must fall before it can count again.
    assign ack_rise_s    = ack & ~ack_prev_r;
    assign launch_last_s = (launch_cnt_r == LAUNCH_LAST);
    assign timeout_hit_s = (32'(wait_cnt_s) >= TIMEOUT_LIM);
    assign wait_clr_s    = (state_r != ST_WAIT_ACK);

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_wait_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (wait_clr_s),
        .enable (1'b1),
        .count  (wait_cnt_s)
    );

    // Next-state selection; a rising ack takes priority over the timeout.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    state_n_s = ST_LAUNCH;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (launch_last_s) begin
                    state_n_s = ST_WAIT_ACK;
                end else begin
                    state_n_s = ST_LAUNCH;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_rise_s) begin
                    state_n_s = ST_NEXT;
                end else if (timeout_hit_s) begin
                    state_n_s = ST_FINISH;
                end else begin
                    state_n_s = ST_WAIT_ACK;
                end
            end
            ST_NEXT: begin
                if (runs_done < runs_cap_r) begin
                    state_n_s = ST_LAUNCH;
                end else begin
                    state_n_s = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State register and strobes, registered from the next state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            req     <= 1'b0;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            req     <= (state_n_s == ST_LAUNCH);
            busy    <= (state_n_s == ST_LAUNCH) || (state_n_s == ST_WAIT_ACK) ||
                       (state_n_s == ST_NEXT);
            finish  <= (state_n_s == ST_FINISH);
        end
    end

    // Launch-length counter and ack history; history reads high for the whole launch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            launch_cnt_r <= 4'd0;
            ack_prev_r   <= 1'b1;
        end else begin
            if ((state_r == ST_LAUNCH) && !launch_last_s) begin
                launch_cnt_r <= launch_cnt_r + 4'd1;
            end else begin
                launch_cnt_r <= 4'd0;
            end
            if (state_n_s == ST_LAUNCH) begin
                ack_prev_r <= 1'b1;
            end else begin
                ack_prev_r <= ack;
            end
        end
    end

    // Batch bookkeeping: capture on go, record each completion, flag an abort.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            runs_cap_r <= 4'd0;
            runs_done  <= 4'd0;
            timeout    <= 1'b0;
            cycles     <= {CNT_BITS{1'b0}};
        end else if ((state_r == ST_IDLE) && go) begin
            runs_cap_r <= norm_runs(runs);
            runs_done  <= 4'd0;
            timeout    <= 1'b0;
        end else if ((state_r == ST_WAIT_ACK) && ack_rise_s) begin
            cycles <= wait_cnt_s;
            if (runs_done != 4'd15) begin
                runs_done <= runs_done + 4'd1;
            end else begin
                runs_done <= runs_done;
            end
        end else if ((state_r == ST_WAIT_ACK) && timeout_hit_s) begin
            timeout <= 1'b1;
        end else begin
            runs_cap_r <= runs_cap_r;
        end
    end

endmodule

// File: tb/tb_req_launcher.sv
// Randomized bench for req_launcher: batch outcomes are predicted per run from
// the ack delay and the timeout limit, then compared against observed outputs.
module tb_req_launcher;

    localparam int RC = 4;
    localparam int T0 = 4095;
    localparam int T1 = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        sel_s;
    logic        go_s;
    logic        ack_s;
    logic [3:0]  runs_s;

    logic        go0, go1, ack0, ack1;
    logic        req0, busy0, fin0, to0;
    logic        req1, busy1, fin1, to1;
    logic [15:0] cyc0, cyc1;
    logic [3:0]  rd0, rd1;

    logic        m_req, m_busy, m_fin, m_to;
    logic [15:0] m_cyc;
    logic [3:0]  m_rd;

    int total = 0;
    int bad   = 0;
    int dly [16];
    int last_cyc [2];

    assign go0  = (sel_s == 1'b0) ? go_s  : 1'b0;
    assign go1  = (sel_s == 1'b1) ? go_s  : 1'b0;
    assign ack0 = (sel_s == 1'b0) ? ack_s : 1'b0;
    assign ack1 = (sel_s == 1'b1) ? ack_s : 1'b0;

    assign m_req  = sel_s ? req1  : req0;
    assign m_busy = sel_s ? busy1 : busy0;
    assign m_fin  = sel_s ? fin1  : fin0;
    assign m_to   = sel_s ? to1   : to0;
    assign m_cyc  = sel_s ? cyc1  : cyc0;
    assign m_rd   = sel_s ? rd1   : rd0;

    req_launcher #(.REQ_CYCLES(RC), .TIMEOUT_CYCLES(T0), .CNT_BITS(16)) dut0 (
        .clock(clock), .reset(reset), .go(go0), .runs(runs_s), .ack(ack0),
        .req(req0), .busy(busy0), .finish(fin0), .timeout(to0),
        .cycles(cyc0), .runs_done(rd0)
    );

    req_launcher #(.REQ_CYCLES(RC), .TIMEOUT_CYCLES(T1), .CNT_BITS(16)) dut1 (
        .clock(clock), .reset(reset), .go(go1), .runs(runs_s), .ack(ack1),
        .req(req1), .busy(busy1), .finish(fin1), .timeout(to1),
        .cycles(cyc1), .runs_done(rd1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One batch on the selected DUT; dly[i] is the WAIT cycle in which run i's ack rises.
    task automatic run_batch(input logic s, input logic [3:0] r, input bit stale);
        int  n, t, exp_done, exp_cyc, kend, len, quiet_bad;
        bit  exp_to;
        sel_s    = s;
        t        = s ? T1 : T0;
        n        = (r == 4'd0) ? 1 : int'(r);
        exp_done = 0;
        exp_cyc  = last_cyc[s];
        exp_to   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (dly[i] <= t) begin
                exp_done++;
                exp_cyc = dly[i];
            end else begin
                exp_to = 1'b1;
                break;
            end
        end

        @(negedge clock);
        chk("idle_before_go", 32'(m_busy), 32'd0);
        ack_s  = stale;
        go_s   = 1'b1;
        runs_s = r;
        @(negedge clock);
        go_s   = 1'b0;
        runs_s = 4'($urandom);
        chk("go_to_req", 32'(m_req), 32'd1);
        chk("go_clears_timeout", 32'(m_to), 32'd0);
        chk("go_clears_runs_done", 32'(m_rd), 32'd0);

        for (int i = 0; i < n; i++) begin
            len = 0;
            while (m_req === 1'b1 && len < 20) begin
                if (!stale && i == 0) ack_s = 1'($urandom_range(0, 1));
                len++;
                @(negedge clock);
            end
            chk("req_len", 32'(len), 32'(RC));
            kend      = (dly[i] <= t) ? dly[i] : t;
            quiet_bad = 0;
            for (int k = 0; k <= kend; k++) begin
                ack_s = (k >= dly[i]) || (stale && i == 0 && k < 2);
                go_s  = (k < kend) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clock);
                if (k < kend && !(m_busy === 1'b1 && m_req === 1'b0 && m_fin === 1'b0))
                    quiet_bad++;
            end
            chk("wait_no_early_end", 32'(quiet_bad), 32'd0);
            if (dly[i] <= t) begin
                chk("ack_cycles", 32'(m_cyc), 32'(dly[i]));
                chk("ack_runs_done", 32'(m_rd), 32'(i + 1));
                chk("next_busy", 32'(m_busy), 32'd1);
                @(negedge clock);
                if (i + 1 < n) chk("ack_to_req", 32'(m_req), 32'd1);
            end else begin
                chk("timeout_flag", 32'(m_to), 32'd1);
                chk("timeout_cycles_kept", 32'(m_cyc), 32'(exp_cyc));
                break;
            end
        end

        chk("finish_pulse", 32'(m_fin), 32'd1);
        chk("finish_not_busy", 32'(m_busy), 32'd0);
        chk("batch_runs_done", 32'(m_rd), 32'(exp_done));
        chk("batch_cycles", 32'(m_cyc), 32'(exp_cyc));
        chk("batch_timeout", 32'(m_to), 32'(exp_to));
        @(negedge clock);
        chk("finish_one_cycle", 32'(m_fin), 32'd0);
        last_cyc[s] = exp_cyc;
        ack_s       = 1'b0;
    endtask

    task automatic reset_mid_run();
        int odd;
        sel_s = 1'b0;
        ack_s = 1'b0;
        @(negedge clock);
        go_s   = 1'b1;
        runs_s = 4'd2;
        @(negedge clock);
        go_s = 1'b0;
        repeat (RC + 6) @(negedge clock);
        chk("pre_reset_busy", 32'(m_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_req", 32'(m_req), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_finish", 32'(m_fin), 32'd0);
        chk("rst_timeout", 32'(m_to), 32'd0);
        chk("rst_cycles", 32'(m_cyc), 32'd0);
        chk("rst_runs_done", 32'(m_rd), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        odd   = 0;
        for (int k = 0; k < 6; k++) begin
            ack_s = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (m_fin !== 1'b0 || m_busy !== 1'b0 || m_req !== 1'b0) odd++;
        end
        chk("post_reset_idle", 32'(odd), 32'd0);
        ack_s       = 1'b0;
        last_cyc[0] = 0;
        last_cyc[1] = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no_end expected end_of_test");
        $fatal(1);
    end

    initial begin
        logic       s;
        logic [3:0] r;
        reset       = 1'b1;
        go_s        = 1'b0;
        ack_s       = 1'b0;
        runs_s      = 4'd0;
        sel_s       = 1'b0;
        last_cyc[0] = 0;
        last_cyc[1] = 0;
        repeat (2) @(negedge clock);
        chk("reset_req", 32'(req0), 32'd0);
        chk("reset_busy", 32'(busy0 | busy1), 32'd0);
        chk("reset_cycles", 32'(cyc0), 32'd0);
        chk("reset_runs_done", 32'(rd0), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_after_reset", 32'(busy0), 32'd0);

        dly[0] = 431;                                  run_batch(1'b0, 4'd1, 1'b0);
        dly[0] = 575;                                  run_batch(1'b0, 4'd1, 1'b1);
        for (int j = 0; j < 16; j++) dly[j] = 10;      run_batch(1'b0, 4'd3, 1'b0);
        dly[0] = 20; dly[1] = 1000;                    run_batch(1'b1, 4'd2, 1'b0);
        dly[0] = T1;                                   run_batch(1'b1, 4'd1, 1'b0);
        dly[0] = 7;                                    run_batch(1'b0, 4'd0, 1'b0);
        for (int j = 0; j < 16; j++) dly[j] = int'($urandom_range(3, 12));
        run_batch(1'b0, 4'd15, 1'b0);

        for (int b = 0; b < 8; b++) begin
            s = 1'($urandom_range(0, 1));
            r = 4'($urandom_range(0, 15));
            for (int j = 0; j < 16; j++)
                dly[j] = s ? int'($urandom_range(3, 115)) : int'($urandom_range(3, 60));
            run_batch(s, r, 1'b0);
        end

        reset_mid_run();
        dly[0] = 33; dly[1] = 5;
        run_batch(1'b0, 4'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
